// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline sequencing unit for the 5-stage RV32I core. It drives
//               the load enables and synchronous clears of the PC and the
//               pipeline registers. It resolves load-use stalls, taken-branch
//               flushes and multi-cycle data-memory waits, and it flags a
//               data-memory timeout. Saturating stall/flush counters are kept
//               for performance debug.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int TIMEOUT = 16,     // max consecutive wait cycles (>= 2)
    parameter int CNT_W   = 16      // width of the debug counters
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             MemRead_EX,
    input  logic [4:0]       wrin_EX,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    input  logic             uses_rs1_ID,
    input  logic             uses_rs2_ID,
    input  logic             branch_taken_EX,
    input  logic             dmem_req,
    input  logic             dmem_ack,
    output logic             PC_WRITE,
    output logic             IFID_WRITE,
    output logic             IDEX_WRITE,
    output logic             EXMEM_WRITE,
    output logic             IFID_CLEAR,
    output logic             IDEX_CLEAR,
    output logic             MEMWB_CLEAR,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    // The wait counter only has to hold values up to TIMEOUT-1.
    localparam int c_WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic                r_mem_timeout;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    r_flush_cnt;

    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_load_use;
    logic w_mem_stall;
    logic w_active;
    logic w_flush_evt;
    logic w_stall_evt;

    // ------------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------------
    // x0 is never a real destination, so a load targeting it cannot create a
    // dependency.
    assign w_rs1_hit   = uses_rs1_ID && (rs1_ID == wrin_EX);
    assign w_rs2_hit   = uses_rs2_ID && (rs2_ID == wrin_EX);
    assign w_load_use  = MemRead_EX && (wrin_EX != 5'd0) && (w_rs1_hit || w_rs2_hit);

    // A dropped request is treated the same as an acknowledge, so in every
    // state "no stall this cycle" is exactly req & !ack being false.
    assign w_mem_stall = dmem_req && !dmem_ack;

    // RUN and MEM_WAIT evaluate the same priority chain; ERROR overrides it.
    assign w_active    = (r_state != ST_ERROR);

    // A branch only takes effect when the pipeline is not frozen by memory.
    assign w_flush_evt = w_active && !w_mem_stall && branch_taken_EX;

    // Any cycle where the PC is held (memory freeze or load-use bubble).
    assign w_stall_evt = w_active && !PC_WRITE;

    // ------------------------------------------------------------------------
    // Mealy pipeline controls: priority is reset, error, memory, branch, load-use
    // ------------------------------------------------------------------------
    always_comb begin
        PC_WRITE    = 1'b1;
        IFID_WRITE  = 1'b1;
        IDEX_WRITE  = 1'b1;
        EXMEM_WRITE = 1'b1;
        IFID_CLEAR  = 1'b0;
        IDEX_CLEAR  = 1'b0;
        MEMWB_CLEAR = 1'b0;

        if (RESET) begin
            PC_WRITE    = 1'b0;
            IFID_WRITE  = 1'b0;
            IDEX_WRITE  = 1'b0;
            EXMEM_WRITE = 1'b0;
            IFID_CLEAR  = 1'b1;
            IDEX_CLEAR  = 1'b1;
            MEMWB_CLEAR = 1'b1;
        end else if (!w_active) begin
            // Pipeline is parked; only bubbles leave the MEM stage.
            PC_WRITE    = 1'b0;
            IFID_WRITE  = 1'b0;
            IDEX_WRITE  = 1'b0;
            EXMEM_WRITE = 1'b0;
            MEMWB_CLEAR = 1'b1;
        end else if (w_mem_stall) begin
            // Freeze everything up to EX/MEM and drain a bubble into WB. A
            // pending branch in EX is held and flushed on completion.
            PC_WRITE    = 1'b0;
            IFID_WRITE  = 1'b0;
            IDEX_WRITE  = 1'b0;
            EXMEM_WRITE = 1'b0;
            MEMWB_CLEAR = 1'b1;
        end else if (branch_taken_EX) begin
            // PC loads the target; the two younger instructions are squashed.
            // A simultaneous load-use hazard is moot because ID is flushed.
            IFID_CLEAR  = 1'b1;
            IDEX_CLEAR  = 1'b1;
        end else if (w_load_use) begin
            // Hold fetch/decode one cycle and send a bubble into EX while the
            // load advances to MEM.
            PC_WRITE    = 1'b0;
            IFID_WRITE  = 1'b0;
            IDEX_CLEAR  = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // State machine: tracks consecutive memory-wait cycles and the timeout
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_mem_stall) begin
                        r_state    <= ST_MEM_WAIT;
                        r_wait_cnt <= c_WAIT_W'(1);
                    end
                end
                ST_MEM_WAIT: begin
                    if (!w_mem_stall) begin
                        r_state    <= ST_RUN;
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt == c_WAIT_LAST) begin
                        r_state       <= ST_ERROR;
                        r_mem_timeout <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
                    end
                end
                ST_ERROR: begin
                    // Only a reset leaves this state.
                    r_mem_timeout <= 1'b1;
                end
                default: begin
                    r_state    <= ST_RUN;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Saturating stall counter: cycles with the PC held outside ERROR
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_stall_cnt <= '0;
        end else if (w_stall_evt && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Saturating flush counter: branch flush events actually applied
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_flush_cnt <= '0;
        end else if (w_flush_evt && !(&r_flush_cnt)) begin
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign mem_timeout = r_mem_timeout;
    assign stall_count = r_stall_cnt;
    assign flush_count = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl. Directed scenarios from
//               the test plan followed by randomized traffic, all compared
//               against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             CLK;
    logic             RESET;
    logic             MemRead_EX;
    logic [4:0]       wrin_EX;
    logic [4:0]       rs1_ID;
    logic [4:0]       rs2_ID;
    logic             uses_rs1_ID;
    logic             uses_rs2_ID;
    logic             branch_taken_EX;
    logic             dmem_req;
    logic             dmem_ack;
    logic             PC_WRITE;
    logic             IFID_WRITE;
    logic             IDEX_WRITE;
    logic             EXMEM_WRITE;
    logic             IFID_CLEAR;
    logic             IDEX_CLEAR;
    logic             MEMWB_CLEAR;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    hazard_ctrl #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .MemRead_EX      (MemRead_EX),
        .wrin_EX         (wrin_EX),
        .rs1_ID          (rs1_ID),
        .rs2_ID          (rs2_ID),
        .uses_rs1_ID     (uses_rs1_ID),
        .uses_rs2_ID     (uses_rs2_ID),
        .branch_taken_EX (branch_taken_EX),
        .dmem_req        (dmem_req),
        .dmem_ack        (dmem_ack),
        .PC_WRITE        (PC_WRITE),
        .IFID_WRITE      (IFID_WRITE),
        .IDEX_WRITE      (IDEX_WRITE),
        .EXMEM_WRITE     (EXMEM_WRITE),
        .IFID_CLEAR      (IFID_CLEAR),
        .IDEX_CLEAR      (IDEX_CLEAR),
        .MEMWB_CLEAR     (MEMWB_CLEAR),
        .mem_timeout     (mem_timeout),
        .stall_count     (stall_count),
        .flush_count     (flush_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp;
    int n_bad;

    // Reference model state: error flag, consecutive unanswered memory
    // cycles, and the two debug counters as plain integers.
    int m_err;
    int m_wait;
    int m_stall;
    int m_flush;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    // Expected controls packed as {PC_W, IFID_W, IDEX_W, EXMEM_W, IFID_C, IDEX_C, MEMWB_C}.
    function automatic logic [6:0] ctl_model(input bit r, input bit err, input bit stall,
                                             input bit br, input bit lu);
        if (r)          return 7'b0000_111;
        else if (err)   return 7'b0000_001;
        else if (stall) return 7'b0000_001;
        else if (br)    return 7'b1111_110;
        else if (lu)    return 7'b0011_010;
        else            return 7'b1111_000;
    endfunction

    // One clock cycle: drive at the falling edge, check the Mealy outputs
    // mid-cycle, advance the model on the rising edge and check registers.
    task automatic cyc(input bit r, input bit mr, input int wr, input int s1, input int s2,
                       input bit u1, input bit u2, input bit br, input bit rq, input bit ak);
        bit         stall;
        bit         lu;
        logic [6:0] exp_ctl;
        @(negedge CLK);
        RESET           = r;
        MemRead_EX      = mr;
        wrin_EX         = wr[4:0];
        rs1_ID          = s1[4:0];
        rs2_ID          = s2[4:0];
        uses_rs1_ID     = u1;
        uses_rs2_ID     = u2;
        branch_taken_EX = br;
        dmem_req        = rq;
        dmem_ack        = ak;
        #2;
        if (r) begin
            m_err = 0; m_wait = 0; m_stall = 0; m_flush = 0;
        end
        stall   = rq && !ak;
        lu      = mr && (wr != 0) && ((u1 && s1 == wr) || (u2 && s2 == wr));
        exp_ctl = ctl_model(r, m_err != 0, stall, br, lu);
        chk("ctl", {PC_WRITE, IFID_WRITE, IDEX_WRITE, EXMEM_WRITE,
                    IFID_CLEAR, IDEX_CLEAR, MEMWB_CLEAR}, 32'(exp_ctl));
        chk("timeout_mid", 32'(mem_timeout), 32'(m_err));
        chk("stall_mid", 32'(stall_count), 32'(m_stall));
        chk("flush_mid", 32'(flush_count), 32'(m_flush));
        @(posedge CLK);
        #1;
        if (!r && m_err == 0) begin
            if (stall) begin
                m_stall = sat_inc(m_stall);
                m_wait++;
                if (m_wait >= TIMEOUT) m_err = 1;
            end else begin
                m_wait = 0;
                if (br)      m_flush = sat_inc(m_flush);
                else if (lu) m_stall = sat_inc(m_stall);
            end
        end
        chk("timeout", 32'(mem_timeout), 32'(m_err));
        chk("stall_cnt", 32'(stall_count), 32'(m_stall));
        chk("flush_cnt", 32'(flush_count), 32'(m_flush));
    endtask

    // Shorthands for the directed part.
    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        m_err = 0; m_wait = 0; m_stall = 0; m_flush = 0;
        RESET = 1'b1; MemRead_EX = 1'b0; wrin_EX = '0; rs1_ID = '0; rs2_ID = '0;
        uses_rs1_ID = 1'b0; uses_rs2_ID = 1'b0; branch_taken_EX = 1'b0;
        dmem_req = 1'b0; dmem_ack = 1'b0;

        do_reset();
        do_reset();
        idle();

        // Load-use on rs1, then the same with x0 as destination.
        cyc(0, 1, 5, 5, 0, 1, 0, 0, 0, 0);
        chk("lu_stall_count", 32'(stall_count), 32'd1);
        cyc(0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("lu_x0_no_stall", 32'(stall_count), 32'd1);

        // Branch with a simultaneous load-use hazard: flush only.
        do_reset();
        cyc(0, 1, 5, 5, 0, 1, 0, 1, 0, 0);
        chk("br_flush_count", 32'(flush_count), 32'd1);
        chk("br_stall_count", 32'(stall_count), 32'd0);

        // Memory wait of three cycles, then acknowledge.
        do_reset();
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        chk("mw_stall_count", 32'(stall_count), 32'd3);
        idle();

        // Same with a branch held: flush only in the completion cycle.
        do_reset();
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        chk("mw_br_no_flush", 32'(flush_count), 32'd0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        chk("mw_br_flush", 32'(flush_count), 32'd1);

        // Timeout: never acknowledge, then drop the request.
        do_reset();
        for (int i = 0; i < TIMEOUT; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("to_flag", 32'(mem_timeout), 32'd1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 5, 5, 0, 1, 0, 1, 0, 0);
        chk("to_sticky", 32'(mem_timeout), 32'd1);
        chk("to_frozen", 32'(stall_count), 32'(TIMEOUT));

        // Reset in the middle of a wait, then a clean restart.
        do_reset();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("rst_mid_stall", 32'(stall_count), 32'd0);
        idle();

        // Saturation: ten load-use stalls on a 3-bit counter.
        do_reset();
        for (int i = 0; i < 10; i++) cyc(0, 1, 7, 0, 7, 0, 1, 0, 0, 0);
        chk("sat_stall", 32'(stall_count), 32'(CNT_MAX));

        // Randomized traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            bit rq;
            rq = ($urandom_range(0, 99) < 45);
            cyc(($urandom_range(0, 79) == 0),
                $urandom_range(0, 1),
                $urandom_range(0, 3),
                $urandom_range(0, 3),
                $urandom_range(0, 3),
                $urandom_range(0, 1),
                $urandom_range(0, 1),
                ($urandom_range(0, 99) < 20),
                rq,
                rq && ($urandom_range(0, 99) < 40));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
